// File: rtl/train_pkg.sv
// Shared types and constants for the train-side track-arbitration sequencer.
package train_pkg;

  localparam int unsigned N_TRAINS = 4;
  localparam int unsigned GRANT_W  = 3;
  localparam int unsigned PEND_W   = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned OWN_W    = 2;

  localparam logic [GRANT_W-1:0] GRANT_NONE = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CROSS,
    ST_GAP
  } train_state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/train_agent.sv
// One train: saturating queued-arrival counter, request FSM and cool-down timer.
module train_agent
  import train_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned PEND_MAX   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         arrive_i,
  input  logic         start_i,
  input  logic         done_i,
  output train_state_e state_o,
  output logic         req_o
);

  localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);

  train_state_e      state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              req_q, req_d;

  // An arrival coinciding with the finishing crossing leaves the queue depth unchanged.
  always_comb begin
    pend_d = pend_q;
    if (arrive_i && !done_i) begin
      if (pend_q < PEND_W'(PEND_MAX)) pend_d = pend_q + PEND_W'(1);
    end else if (done_i && !arrive_i) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if ((pend_q != '0) || arrive_i) begin
          state_d = ST_WAIT;
          req_d   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (start_i) state_d = ST_CROSS;
      end
      ST_CROSS: begin
        if (done_i) begin
          req_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      gap_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      req_q   <= req_d;
    end
  end

  assign state_o = state_q;
  assign req_o   = req_q;

endmodule

// File: rtl/train_side_sequencer.sv
// Train-side end of the track handshake: four train agents, the single-track
// interlock and crossing timer, done/crossing flags, grant checker and crossing count.
module train_side_sequencer
  import train_pkg::*;
#(
  parameter int unsigned CROSS_CYCLES = 5,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned PEND_MAX     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_TRAINS-1:0] arrive,
  input  logic [GRANT_W-1:0]  grant,
  output logic [N_TRAINS-1:0] train_request,
  output logic                train_done,
  output logic                crossing,
  output logic                proto_err,
  output logic [CNT_W-1:0]    crossings_cnt
);

  localparam int unsigned XCNT_W = cnt_width(CROSS_CYCLES);

  train_state_e        st [N_TRAINS];
  logic [N_TRAINS-1:0] start_c, agent_done_c;
  logic                finish_c, viol_c;

  logic                crossing_q, crossing_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [XCNT_W-1:0]   xcnt_q, xcnt_d;
  logic                done_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  for (genvar i = 0; i < N_TRAINS; i++) begin : g_agent
    train_agent #(
      .GAP_CYCLES (GAP_CYCLES),
      .PEND_MAX   (PEND_MAX)
    ) u_agent (
      .clk      (clk),
      .reset    (reset),
      .arrive_i (arrive[i]),
      .start_i  (start_c[i]),
      .done_i   (agent_done_c[i]),
      .state_o  (st[i]),
      .req_o    (train_request[i])
    );
  end

  // A waiting train may only enter the track while nobody else is on it.
  always_comb begin
    start_c = '0;
    for (int i = 0; i < N_TRAINS; i++) begin
      if ((st[i] == ST_WAIT) && (grant == GRANT_W'(i + 1)) && !crossing_q) start_c[i] = 1'b1;
    end
  end

  assign finish_c = crossing_q && (xcnt_q == '0);

  always_comb begin
    agent_done_c          = '0;
    agent_done_c[owner_q] = finish_c;
  end

  always_comb begin
    viol_c = 1'b0;
    if (grant > GRANT_W'(N_TRAINS)) begin
      viol_c = 1'b1;
    end else if ((grant != GRANT_NONE) && !train_request[OWN_W'(grant - GRANT_W'(1))]) begin
      viol_c = 1'b1;
    end
    if (crossing_q && (grant != (GRANT_W'(owner_q) + GRANT_W'(1)))) viol_c = 1'b1;
  end

  always_comb begin
    crossing_d = crossing_q;
    owner_d    = owner_q;
    xcnt_d     = xcnt_q;
    if (start_c != '0) begin
      crossing_d = 1'b1;
      xcnt_d     = XCNT_W'(CROSS_CYCLES - 1);
      for (int i = 0; i < N_TRAINS; i++) begin
        if (start_c[i]) owner_d = OWN_W'(i);
      end
    end else if (crossing_q) begin
      if (finish_c) crossing_d = 1'b0;
      else          xcnt_d     = xcnt_q - XCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crossing_q <= 1'b0;
      owner_q    <= '0;
      xcnt_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      crossing_q <= crossing_d;
      owner_q    <= owner_d;
      xcnt_q     <= xcnt_d;
      done_q     <= finish_c;
      err_q      <= err_q | viol_c;
      cnt_q      <= cnt_q + CNT_W'(finish_c);
    end
  end

  assign train_done    = done_q;
  assign crossing      = crossing_q;
  assign proto_err     = err_q;
  assign crossings_cnt = cnt_q;

endmodule
